demux_3_8_reg: RTL and testbench

DEMUX_3_8_REG -- requirements
Module: demux_3_8_reg

---
 rtl/demux_3_8_reg_pkg.sv | 25 ++
 rtl/demux_3_8_reg_pri_enc.sv | 25 ++
 rtl/demux_3_8_reg.sv | 147 ++++++++++++++
 tb/tb_demux_3_8_reg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_3_8_reg_pkg.sv
// Shared processor package: demux widths, FSM state encoding and the
// latched sweep context. Also used by the priority encoder, which is shared
// with the load/store-multiple sequencing logic.
package demux_3_8_reg_pkg;

    localparam int unsigned NUM_OUT = 8;   // number of destination registers
    localparam int unsigned DATA_W  = 3;   // width of each destination value
    localparam int unsigned IDX_W   = 3;   // width of a destination index

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [NUM_OUT-1:0] mask_t;

    // Payload captured when a sweep is accepted; the sweep runs from this
    // copy, so later changes on inp/mask have no effect on it.
    typedef struct packed {
        mask_t mask;
        data_t data;
    } sweep_ctx_t;

endpackage

// File: rtl/demux_3_8_reg_pri_enc.sv
// pri_enc_8_3: lowest-set-bit priority encoder (combinational).
// Ports:
//   i_req     - request vector, bit 0 has the highest priority
//   o_idx_c   - index of the lowest set bit (0 when no bit is set)
//   o_vld_c   - high when any bit of i_req is set
module pri_enc_8_3
    import demux_3_8_reg_pkg::*;
(
    input  logic [NUM_OUT-1:0] i_req,
    output logic [IDX_W-1:0]   o_idx_c,
    output logic               o_vld_c
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        o_idx_c = '0;
        o_vld_c = |i_req;
        for (int i = int'(NUM_OUT) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/demux_3_8_reg.sv
// demux_3_8_reg: registered 1-to-8 demultiplexer with a masked sweep mode.
// A single write (wr) stores inp into out<sel>. A sweep (bcast) latches inp
// and mask, then writes the latched value into one masked destination per
// cycle, lowest index first, pulsing done when the last one is written.
// Ports:
//   clk         - clock, all state updates on the rising edge
//   reset       - synchronous active-high reset
//   inp         - data to distribute
//   sel         - destination index for a single write
//   wr          - single-write request (IDLE only)
//   bcast       - sweep request (IDLE only, wins over wr)
//   mask        - sweep destination set, bit i selects out<i>
//   out0..out7  - registered destination values
//   vld         - bit i set once out<i> has been written (cleared by reset)
//   busy        - high while a sweep is in progress
//   done        - one-cycle pulse when a sweep completes
module demux_3_8_reg
    import demux_3_8_reg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  inp,
    input  logic [IDX_W-1:0]   sel,
    input  logic               wr,
    input  logic               bcast,
    input  logic [NUM_OUT-1:0] mask,
    output logic [DATA_W-1:0]  out0,
    output logic [DATA_W-1:0]  out1,
    output logic [DATA_W-1:0]  out2,
    output logic [DATA_W-1:0]  out3,
    output logic [DATA_W-1:0]  out4,
    output logic [DATA_W-1:0]  out5,
    output logic [DATA_W-1:0]  out6,
    output logic [DATA_W-1:0]  out7,
    output logic [NUM_OUT-1:0] vld,
    output logic               busy,
    output logic               done
);

    state_e                          r_state;
    state_e                          w_state_nxt;
    sweep_ctx_t                      r_ctx;
    sweep_ctx_t                      w_ctx_nxt;
    logic [NUM_OUT-1:0][DATA_W-1:0]  r_out;
    logic [NUM_OUT-1:0][DATA_W-1:0]  w_out_nxt;
    mask_t                           r_vld;
    mask_t                           w_vld_nxt;
    logic                            r_busy;
    logic                            w_busy_nxt;
    logic                            r_done;
    logic                            w_done_nxt;

    logic [IDX_W-1:0]                w_idx;
    logic                            w_idx_vld;
    mask_t                           w_mask_rem;

    // Next destination of the sweep: lowest bit still set in the latched mask.
    pri_enc_8_3 u_pri_enc (
        .i_req   (r_ctx.mask),
        .o_idx_c (w_idx),
        .o_vld_c (w_idx_vld)
    );

    // Mask left after this cycle's sweep write.
    assign w_mask_rem = r_ctx.mask & ~(mask_t'(1) << w_idx);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ctx   <= '0;
            r_out   <= '0;
            r_vld   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ctx   <= w_ctx_nxt;
            r_out   <= w_out_nxt;
            r_vld   <= w_vld_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ctx_nxt   = r_ctx;
        w_out_nxt   = r_out;
        w_vld_nxt   = r_vld;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bcast) begin
                    // Sweep has priority; a simultaneous single write is dropped.
                    w_ctx_nxt.mask = mask;
                    w_ctx_nxt.data = inp;
                    if (|mask) begin
                        w_state_nxt = ST_SWEEP;
                    end else begin
                        // Empty sweep: nothing to write, complete at once.
                        w_done_nxt = 1'b1;
                    end
                end else if (wr) begin
                    w_out_nxt[sel] = inp;
                    w_vld_nxt[sel] = 1'b1;
                end
            end

            ST_SWEEP: begin
                if (w_idx_vld) begin
                    w_out_nxt[w_idx] = r_ctx.data;
                    w_vld_nxt[w_idx] = 1'b1;
                    w_ctx_nxt.mask   = w_mask_rem;
                    if (w_mask_rem == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    // Unreachable with a non-empty mask on entry; recover.
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_SWEEP);
    end

    assign out0 = r_out[0];
    assign out1 = r_out[1];
    assign out2 = r_out[2];
    assign out3 = r_out[3];
    assign out4 = r_out[4];
    assign out5 = r_out[5];
    assign out6 = r_out[6];
    assign out7 = r_out[7];
    assign vld  = r_vld;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_demux_3_8_reg.sv
module tb_demux_3_8_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] inp = '0;
    logic [2:0] sel = '0;
    logic       wr = 1'b0;
    logic       bcast = 1'b0;
    logic [7:0] mask = '0;
    logic [2:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0] vld;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demux_3_8_reg dut (
        .clk   (clk),
        .reset (reset),
        .inp   (inp),
        .sel   (sel),
        .wr    (wr),
        .bcast (bcast),
        .mask  (mask),
        .out0  (out0),
        .out1  (out1),
        .out2  (out2),
        .out3  (out3),
        .out4  (out4),
        .out5  (out5),
        .out6  (out6),
        .out7  (out7),
        .vld   (vld),
        .busy  (busy),
        .done  (done)
    );

    // Reference model: pending sweep destinations kept as a queue of indices.
    int         m_out [8];
    logic [7:0] m_vld;
    bit         m_busy;
    bit         m_done;
    int         m_q [$];
    int         m_data;

    function automatic int dut_out(input int idx);
        case (idx)
            0: return int'(out0);
            1: return int'(out1);
            2: return int'(out2);
            3: return int'(out3);
            4: return int'(out4);
            5: return int'(out5);
            6: return int'(out6);
            default: return int'(out7);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            foreach (m_out[i]) m_out[i] = 0;
            m_vld  = '0;
            m_busy = 0;
            m_done = 0;
            m_data = 0;
            m_q.delete();
        end else begin
            m_done = 0;
            if (m_q.size() > 0) begin
                int idx;
                idx = m_q.pop_front();
                m_out[idx] = m_data;
                m_vld[idx] = 1'b1;
                if (m_q.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (bcast) begin
                m_data = int'(inp);
                for (int i = 0; i < 8; i++) if (mask[i]) m_q.push_back(i);
                if (m_q.size() == 0) m_done = 1;
                else m_busy = 1;
            end else if (wr) begin
                m_out[sel] = int'(inp);
                m_vld[sel] = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 8; i++) chk($sformatf("model out%0d", i), dut_out(i), m_out[i]);
        chk("model vld", int'(vld), int'(m_vld));
        chk("model busy", int'(busy), int'(m_busy));
        chk("model done", int'(done), int'(m_done));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        reset = 0; wr = 0; bcast = 0; sel = '0; inp = '0; mask = '0;
    endtask

    typedef struct {
        bit       rst;
        bit       wr;
        bit       bc;
        bit [2:0] sel;
        bit [2:0] inp;
        bit [7:0] mask;
        bit [7:0] e_vld;
        bit       e_busy;
        bit       e_done;
        int       p_idx;
        int       p_val;
    } vec_t;

    vec_t vt [14];

    initial begin
        int busy_cnt;
        int guard;

        //          rst wr bc sel inp mask   e_vld  busy done pidx pval
        vt[0]  = '{1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 5, 6, 8'h00, 8'h20, 0, 0, 5, 6};
        vt[2]  = '{0, 0, 0, 0, 0, 8'h00, 8'h20, 0, 0, 0, 0};
        vt[3]  = '{0, 0, 1, 0, 3, 8'hA5, 8'h20, 1, 0, 0, 0};
        vt[4]  = '{0, 1, 0, 3, 7, 8'h00, 8'h21, 1, 0, 0, 3};
        vt[5]  = '{0, 1, 1, 3, 7, 8'h18, 8'h25, 1, 0, 2, 3};
        vt[6]  = '{0, 0, 0, 0, 0, 8'h00, 8'h25, 1, 0, 5, 3};
        vt[7]  = '{0, 0, 0, 0, 0, 8'h00, 8'hA5, 0, 1, 7, 3};
        vt[8]  = '{0, 0, 0, 0, 0, 8'h00, 8'hA5, 0, 0, 3, 0};
        vt[9]  = '{0, 0, 1, 0, 5, 8'h00, 8'hA5, 0, 1, 1, 0};
        vt[10] = '{0, 0, 0, 0, 0, 8'h00, 8'hA5, 0, 0, 1, 0};
        vt[11] = '{0, 1, 1, 1, 2, 8'h80, 8'hA5, 1, 0, 1, 0};
        vt[12] = '{0, 0, 0, 0, 0, 8'h00, 8'hA5, 0, 1, 7, 2};
        vt[13] = '{0, 0, 0, 0, 0, 8'h00, 8'hA5, 0, 0, 1, 0};

        for (int k = 0; k < 14; k++) begin
            reset = vt[k].rst; wr = vt[k].wr; bcast = vt[k].bc;
            sel = vt[k].sel; inp = vt[k].inp; mask = vt[k].mask;
            step();
            chk($sformatf("vec%0d vld", k), int'(vld), int'(vt[k].e_vld));
            chk($sformatf("vec%0d busy", k), int'(busy), int'(vt[k].e_busy));
            chk($sformatf("vec%0d done", k), int'(done), int'(vt[k].e_done));
            chk($sformatf("vec%0d out%0d", k, vt[k].p_idx), dut_out(vt[k].p_idx), vt[k].p_val);
        end

        // Full sweep with inputs churning while it runs.
        idle_inputs();
        bcast = 1; mask = 8'hFF; inp = 3'd5;
        step();
        busy_cnt = int'(busy);
        guard = 0;
        while (busy && guard < 20) begin
            wr = 1'($urandom); bcast = 1'($urandom); sel = 3'($urandom);
            inp = 3'($urandom); mask = 8'($urandom);
            step();
            if (busy) busy_cnt++;
            guard++;
        end
        idle_inputs();
        chk("sweep FF busy cycles", busy_cnt, 8);
        chk("sweep FF done", int'(done), 1);
        chk("sweep FF vld", int'(vld), 8'hFF);
        for (int i = 0; i < 8; i++) chk($sformatf("sweep FF out%0d", i), dut_out(i), 5);
        step();

        // Reset in the middle of a sweep aborts it without a done pulse.
        reset = 1; step();
        idle_inputs();
        bcast = 1; mask = 8'hFF; inp = 3'd4;
        step();
        idle_inputs();
        guard = 0;
        while (vld != 8'h07 && guard < 20) begin
            step();
            guard++;
        end
        chk("abort reached vld 07", int'(vld), 8'h07);
        chk("abort out2 written", int'(out2), 4);
        reset = 1;
        step();
        reset = 0;
        chk("abort vld cleared", int'(vld), 0);
        chk("abort busy cleared", int'(busy), 0);
        for (int i = 0; i < 8; i++) chk($sformatf("abort out%0d", i), dut_out(i), 0);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("abort no done", int'(done), 0);
            chk("abort vld stays 0", int'(vld), 0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            wr    = 1'($urandom);
            bcast = ($urandom_range(0, 5) == 0);
            sel   = 3'($urandom);
            inp   = 3'($urandom);
            mask  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            step();
        end
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
